// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state encodings shared by the command sequencer and the downstream ALU.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    // Reference evaluation for the combinational ALU; shifts use the low 3 bits of b.
    function automatic logic [7:0] alu_eval(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        return op == OP_ADD ? a + b :
               op == OP_SUB ? a - b :
               op == OP_SLL ? a << b[2:0] :
               op == OP_SRL ? a >> b[2:0] :
               op == OP_AND ? a & b :
               op == OP_OR  ? a | b :
               op == OP_XOR ? a ^ b : {7'd0, a == b};
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 8-bit register file, one write port, two asynchronous read ports, async active-low clear.
module alu_regfile #(
    parameter int NREG = 4,
    localparam int AW = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [7:0]    wd,
    input  logic [AW-1:0] ra,
    input  logic [AW-1:0] rb,
    output logic [7:0]    rda,
    output logic [7:0]    rdb
);

    logic [7:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

    assign rda = regs[ra];
    assign rdb = regs[rb];

endmodule

// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: accepts load/ALU commands, feeds registered operands to an external ALU,
// and reports each register write-back through a valid/ready handshake.
module alu_cmd_seq
    import alu_pkg::*;
#(
    parameter int NREG = 4,
    localparam int AW = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_ld,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs,
    input  logic [AW-1:0] cmd_rt,
    input  logic [7:0]    cmd_imm,
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    output logic [2:0]    alu_op,
    input  logic [7:0]    alu_res,
    output logic          wb_valid,
    output logic [7:0]    wb_data,
    output logic [AW-1:0] wb_rd,
    input  logic          wb_ready
);

    logic [1:0]    state;
    logic [7:0]    rs_data;
    logic [7:0]    rt_data;
    logic          accept;
    logic          in_exec;
    logic          we;
    logic [AW-1:0] wa;
    logic [7:0]    wd;

    assign cmd_ready = rst_n && state == S_IDLE;
    assign wb_valid  = state == S_WB;
    assign accept    = cmd_valid && cmd_ready;
    assign in_exec   = state == S_EXEC;

    // Loads write on acceptance; ALU results write only at the end of EXEC,
    // so operands read at acceptance always see pre-write values.
    assign we = (accept && cmd_ld) || in_exec;
    assign wa = in_exec ? wb_rd : cmd_rd;
    assign wd = in_exec ? alu_res : cmd_imm;

    alu_regfile #(.NREG(NREG)) u_regfile (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (we),
        .wa   (wa),
        .wd   (wd),
        .ra   (cmd_rs),
        .rb   (cmd_rt),
        .rda  (rs_data),
        .rdb  (rt_data)
    );

    // wb_rd doubles as the latched destination index from acceptance onward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            wb_data <= '0;
            wb_rd   <= '0;
        end else if (accept) begin
            wb_rd <= cmd_rd;
            if (cmd_ld) begin
                state   <= S_WB;
                wb_data <= cmd_imm;
            end else begin
                state  <= S_EXEC;
                alu_a  <= rs_data;
                alu_b  <= rt_data;
                alu_op <= cmd_op;
            end
        end else if (in_exec) begin
            state   <= S_WB;
            wb_data <= alu_res;
        end else if (state == S_WB && wb_ready) begin
            state <= S_IDLE;
        end
    end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// tb_alu_cmd_seq: directed vector table plus hand-written stall and mid-command reset sequences.
module tb_alu_cmd_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_ld;
    logic [2:0] cmd_op;
    logic [1:0] cmd_rd, cmd_rs, cmd_rt;
    logic [7:0] cmd_imm;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_res;
    logic       wb_valid;
    logic [7:0] wb_data;
    logic [1:0] wb_rd;
    logic       wb_ready;

    int total = 0;
    int passed = 0;

    alu_cmd_seq #(.NREG(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_ld   (cmd_ld),
        .cmd_op   (cmd_op),
        .cmd_rd   (cmd_rd),
        .cmd_rs   (cmd_rs),
        .cmd_rt   (cmd_rt),
        .cmd_imm  (cmd_imm),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_res  (alu_res),
        .wb_valid (wb_valid),
        .wb_data  (wb_data),
        .wb_rd    (wb_rd),
        .wb_ready (wb_ready)
    );

    always #5 clk = ~clk;

    // Behavioural downstream ALU.
    always_comb begin
        alu_res = 8'd0;
        case (alu_op)
            3'b000: alu_res = alu_a + alu_b;
            3'b001: alu_res = alu_a - alu_b;
            3'b010: alu_res = alu_a << alu_b[2:0];
            3'b011: alu_res = alu_a >> alu_b[2:0];
            3'b100: alu_res = alu_a & alu_b;
            3'b101: alu_res = alu_a | alu_b;
            3'b110: alu_res = alu_a ^ alu_b;
            default: alu_res = {7'd0, alu_a == alu_b};
        endcase
    end

    typedef struct {
        logic       ld;
        logic [2:0] op;
        logic [1:0] rd, rs, rt;
        logic [7:0] imm;
        logic [7:0] a, b;
        logic [7:0] data;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                        input logic [1:0] rs, input logic [1:0] rt, input logic [7:0] imm);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_ld = ld; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt; cmd_imm = imm;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        send(v.ld, v.op, v.rd, v.rs, v.rt, v.imm);
        if (v.ld) begin
            chk($sformatf("v%0d_ld_valid_n1", idx), {31'd0, wb_valid}, 32'd1);
        end else begin
            chk($sformatf("v%0d_exec_valid", idx), {31'd0, wb_valid}, 32'd0);
            chk($sformatf("v%0d_alu_a", idx), {24'd0, alu_a}, {24'd0, v.a});
            chk($sformatf("v%0d_alu_b", idx), {24'd0, alu_b}, {24'd0, v.b});
            chk($sformatf("v%0d_alu_op", idx), {29'd0, alu_op}, {29'd0, v.op});
            @(negedge clk);
            chk($sformatf("v%0d_alu_valid_n2", idx), {31'd0, wb_valid}, 32'd1);
        end
        chk($sformatf("v%0d_wb_data", idx), {24'd0, wb_data}, {24'd0, v.data});
        chk($sformatf("v%0d_wb_rd", idx), {30'd0, wb_rd}, {30'd0, v.rd});
        @(negedge clk);
        chk($sformatf("v%0d_idle_valid", idx), {31'd0, wb_valid}, 32'd0);
        if (!v.ld) chk($sformatf("v%0d_alu_a_hold", idx), {24'd0, alu_a}, {24'd0, v.a});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        //              ld   op      rd     rs     rt     imm     a       b       data
        vecs[0]  = '{1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 8'd20,  8'd0,   8'd0,   8'd20};
        vecs[1]  = '{1'b1, 3'b000, 2'd1, 2'd0, 2'd0, 8'd15,  8'd0,   8'd0,   8'd15};
        vecs[2]  = '{1'b0, 3'b000, 2'd2, 2'd0, 2'd1, 8'd0,   8'd20,  8'd15,  8'd35};
        vecs[3]  = '{1'b0, 3'b001, 2'd3, 2'd0, 2'd1, 8'd0,   8'd20,  8'd15,  8'd5};
        vecs[4]  = '{1'b0, 3'b110, 2'd0, 2'd0, 2'd0, 8'd0,   8'd20,  8'd20,  8'd0};
        vecs[5]  = '{1'b0, 3'b000, 2'd3, 2'd0, 2'd1, 8'd0,   8'd0,   8'd15,  8'd15};
        vecs[6]  = '{1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 8'd200, 8'd0,   8'd0,   8'd200};
        vecs[7]  = '{1'b1, 3'b000, 2'd1, 2'd0, 2'd0, 8'd100, 8'd0,   8'd0,   8'd100};
        vecs[8]  = '{1'b0, 3'b000, 2'd2, 2'd0, 2'd1, 8'd0,   8'd200, 8'd100, 8'd44};
        vecs[9]  = '{1'b1, 3'b000, 2'd3, 2'd0, 2'd0, 8'd3,   8'd0,   8'd0,   8'd3};
        vecs[10] = '{1'b0, 3'b010, 2'd2, 2'd1, 2'd3, 8'd0,   8'd100, 8'd3,   8'd32};
        vecs[11] = '{1'b0, 3'b011, 2'd2, 2'd0, 2'd3, 8'd0,   8'd200, 8'd3,   8'd25};
        vecs[12] = '{1'b0, 3'b100, 2'd2, 2'd0, 2'd1, 8'd0,   8'd200, 8'd100, 8'd64};
        vecs[13] = '{1'b0, 3'b101, 2'd2, 2'd0, 2'd1, 8'd0,   8'd200, 8'd100, 8'd236};
        vecs[14] = '{1'b0, 3'b111, 2'd2, 2'd0, 2'd0, 8'd0,   8'd200, 8'd200, 8'd1};
        vecs[15] = '{1'b0, 3'b001, 2'd1, 2'd1, 2'd0, 8'd0,   8'd100, 8'd200, 8'd156};
        vecs[16] = '{1'b0, 3'b111, 2'd2, 2'd1, 2'd0, 8'd0,   8'd156, 8'd200, 8'd0};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_ld = 1'b0; cmd_op = 3'd0;
        cmd_rd = 2'd0; cmd_rs = 2'd0; cmd_rt = 2'd0; cmd_imm = 8'd0; wb_ready = 1'b1;
        #3;
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
        chk("rst_alu_b", {24'd0, alu_b}, 32'd0);
        chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
        chk("rst_wb_data", {24'd0, wb_data}, 32'd0);
        chk("rst_wb_rd", {30'd0, wb_rd}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);

        for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

        // Back-pressure: report must hold steady and new commands must be ignored.
        wb_ready = 1'b0;
        send(1'b1, 3'b000, 2'd2, 2'd0, 2'd0, 8'd77);
        cmd_valid = 1'b1; cmd_ld = 1'b1; cmd_rd = 2'd3; cmd_imm = 8'd9;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d_valid", i), {31'd0, wb_valid}, 32'd1);
            chk($sformatf("stall%0d_data", i), {24'd0, wb_data}, 32'd77);
            chk($sformatf("stall%0d_rd", i), {30'd0, wb_rd}, 32'd2);
            chk($sformatf("stall%0d_ready", i), {31'd0, cmd_ready}, 32'd0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        wb_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_valid", {31'd0, wb_valid}, 32'd0);
        send(1'b0, 3'b000, 2'd1, 2'd3, 2'd2, 8'd0);
        chk("stall_r3_unwritten", {24'd0, alu_a}, 32'd3);
        chk("stall_r2_loaded", {24'd0, alu_b}, 32'd77);
        @(negedge clk);
        chk("stall_add_data", {24'd0, wb_data}, 32'd80);
        @(negedge clk);

        // Reset in the middle of EXEC aborts the command and clears everything.
        send(1'b0, 3'b000, 2'd2, 2'd0, 2'd1, 8'd0);
        chk("abort_pre_alu_a", {24'd0, alu_a}, 32'd200);
        rst_n = 1'b0;
        #1;
        chk("abort_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("abort_alu_a", {24'd0, alu_a}, 32'd0);
        chk("abort_wb_data", {24'd0, wb_data}, 32'd0);
        @(negedge clk);
        chk("abort_hold_valid", {31'd0, wb_valid}, 32'd0);
        rst_n = 1'b1;
        #1 chk("abort_rel_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        send(1'b0, 3'b000, 2'd3, 2'd0, 2'd1, 8'd0);
        chk("abort_r0", {24'd0, alu_a}, 32'd0);
        chk("abort_r1", {24'd0, alu_b}, 32'd0);
        @(negedge clk);
        chk("abort_sum", {24'd0, wb_data}, 32'd0);
        @(negedge clk);
        send(1'b0, 3'b101, 2'd0, 2'd2, 2'd3, 8'd0);
        chk("abort_r2", {24'd0, alu_a}, 32'd0);
        chk("abort_r3", {24'd0, alu_b}, 32'd0);
        @(negedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
